// File: rtl/board_render_fsm.sv
// Board update and redraw sequencer. It erases each player's old cell, writes the
// new cells, then scans the board RAM and emits every tile pixel by pixel.
module board_render_fsm #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int TILE    = 16,
    parameter int NUM_P   = 2,
    parameter int COORD_W = 4,
    parameter int COL_W   = 3,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int A_W     = 8,
    parameter logic [COL_W-1:0] BG_COL  = 3'b000,
    parameter logic [COL_W-1:0] HIT_COL = 3'b110
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_P*COORD_W-1:0]   p_x,
    input  logic [NUM_P*COORD_W-1:0]   p_y,
    input  logic [NUM_P-1:0]           p_valid,
    input  logic [NUM_P*COL_W-1:0]     p_col,
    output logic [A_W-1:0]             mem_addr,
    output logic [COL_W-1:0]           mem_wdata,
    output logic                       mem_we,
    input  logic [COL_W-1:0]           mem_rdata,
    output logic [X_W-1:0]             oX,
    output logic [Y_W-1:0]             oY,
    output logic [COL_W-1:0]           oColour,
    output logic                       plot_enable,
    output logic                       busy,
    output logic                       done
);

    localparam int CX_W   = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int CY_W   = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int PIX_W  = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int SLOT_W = (NUM_P > 1) ? $clog2(NUM_P) : 1;

    typedef enum logic [2:0] {IDLE, ERASE, WRITE, RD_REQ, RD_WAIT, PAINT, DONE} state_t;

    typedef struct packed {
        logic             we;
        logic [A_W-1:0]   addr;
        logic [COL_W-1:0] data;
    } mem_cmd_t;

    state_t                     state;
    logic [NUM_P*COORD_W-1:0]   lat_x, lat_y, prev_x, prev_y;
    logic [NUM_P-1:0]           lat_valid, prev_valid;
    logic [NUM_P*COL_W-1:0]     lat_col;
    logic [SLOT_W-1:0]          slot;
    logic [CX_W-1:0]            cx;
    logic [CY_W-1:0]            cy;
    logic [PIX_W-1:0]           px, py;

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (int'(x) < GRID_W) && (int'(y) < GRID_H);
    endfunction

    function automatic logic [A_W-1:0] cell_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return A_W'(int'(y) * GRID_W + int'(x));
    endfunction

    function automatic mem_cmd_t erase_cmd(input int i);
        mem_cmd_t c;
        logic [COORD_W-1:0] x, y;
        x      = prev_x[i*COORD_W +: COORD_W];
        y      = prev_y[i*COORD_W +: COORD_W];
        c.we   = prev_valid[i] && in_range(x, y);
        c.addr = c.we ? cell_addr(x, y) : '0;
        c.data = c.we ? BG_COL : '0;
        return c;
    endfunction

    // Two valid slots sharing a cell both write the collision colour.
    function automatic mem_cmd_t write_cmd(input int i);
        mem_cmd_t c;
        logic [COORD_W-1:0] x, y, xj, yj;
        logic hit;
        x   = lat_x[i*COORD_W +: COORD_W];
        y   = lat_y[i*COORD_W +: COORD_W];
        hit = 1'b0;
        for (int j = 0; j < NUM_P; j++) begin
            xj = lat_x[j*COORD_W +: COORD_W];
            yj = lat_y[j*COORD_W +: COORD_W];
            if (j != i && lat_valid[j] && in_range(xj, yj) && xj == x && yj == y)
                hit = 1'b1;
        end
        c.we   = lat_valid[i] && in_range(x, y);
        c.addr = c.we ? cell_addr(x, y) : '0;
        c.data = c.we ? (hit ? HIT_COL : lat_col[i*COL_W +: COL_W]) : '0;
        return c;
    endfunction

    function automatic logic [X_W-1:0] pix_x(input logic [CX_W-1:0] c, input logic [PIX_W-1:0] p);
        return X_W'(c) * X_W'(TILE) + X_W'(p);
    endfunction

    function automatic logic [Y_W-1:0] pix_y(input logic [CY_W-1:0] c, input logic [PIX_W-1:0] p);
        return Y_W'(c) * Y_W'(TILE) + Y_W'(p);
    endfunction

    // NOTE: outputs are registered, so each transition loads the values for the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            plot_enable <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            oX          <= '0;
            oY          <= '0;
            oColour     <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_valid   <= '0;
            lat_col     <= '0;
            prev_x      <= '0;
            prev_y      <= '0;
            prev_valid  <= '0;
            slot        <= '0;
            cx          <= '0;
            cy          <= '0;
            px          <= '0;
            py          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_x     <= p_x;
                        lat_y     <= p_y;
                        lat_valid <= p_valid;
                        lat_col   <= p_col;
                        busy      <= 1'b1;
                        slot      <= '0;
                        state     <= ERASE;
                        {mem_we, mem_addr, mem_wdata} <= erase_cmd(0);
                    end
                end
                ERASE: begin
                    if (slot == SLOT_W'(NUM_P - 1)) begin
                        slot  <= '0;
                        state <= WRITE;
                        {mem_we, mem_addr, mem_wdata} <= write_cmd(0);
                    end else begin
                        slot <= slot + 1'b1;
                        {mem_we, mem_addr, mem_wdata} <= erase_cmd(int'(slot) + 1);
                    end
                end
                WRITE: begin
                    if (slot == SLOT_W'(NUM_P - 1)) begin
                        prev_x     <= lat_x;
                        prev_y     <= lat_y;
                        prev_valid <= lat_valid;
                        slot       <= '0;
                        cx         <= '0;
                        cy         <= '0;
                        mem_we     <= 1'b0;
                        mem_wdata  <= '0;
                        mem_addr   <= '0;
                        state      <= RD_REQ;
                    end else begin
                        slot <= slot + 1'b1;
                        {mem_we, mem_addr, mem_wdata} <= write_cmd(int'(slot) + 1);
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    oColour     <= mem_rdata;
                    plot_enable <= 1'b1;
                    px          <= '0;
                    py          <= '0;
                    oX          <= pix_x(cx, '0);
                    oY          <= pix_y(cy, '0);
                    state       <= PAINT;
                end
                PAINT: begin
                    if (px != PIX_W'(TILE - 1)) begin
                        px <= px + 1'b1;
                        oX <= pix_x(cx, px + 1'b1);
                    end else if (py != PIX_W'(TILE - 1)) begin
                        px <= '0;
                        py <= py + 1'b1;
                        oX <= pix_x(cx, '0);
                        oY <= pix_y(cy, py + 1'b1);
                    end else begin
                        px          <= '0;
                        py          <= '0;
                        plot_enable <= 1'b0;
                        if (cx == CX_W'(GRID_W - 1) && cy == CY_W'(GRID_H - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (cx == CX_W'(GRID_W - 1)) begin
                            cx       <= '0;
                            cy       <= cy + 1'b1;
                            mem_addr <= A_W'((int'(cy) + 1) * GRID_W);
                            state    <= RD_REQ;
                        end else begin
                            cx       <= cx + 1'b1;
                            mem_addr <= A_W'(int'(cy) * GRID_W + int'(cx) + 1);
                            state    <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_render_fsm.sv
// Scoreboard bench for board_render_fsm: a behavioural board model queues the expected
// RAM writes and pixel stream, and a negedge monitor pops and compares them.
module tb_board_render_fsm;

    localparam int GRID_W  = 16;
    localparam int GRID_H  = 16;
    localparam int TILE    = 4;
    localparam int NUM_P   = 2;
    localparam int COORD_W = 5;
    localparam int COL_W   = 3;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int A_W     = 8;
    localparam logic [COL_W-1:0] BG_COL  = 3'b000;
    localparam logic [COL_W-1:0] HIT_COL = 3'b110;
    localparam int CELLS = GRID_W * GRID_H;
    localparam int LAT   = 2 * NUM_P + CELLS * (2 + TILE * TILE) + 1;

    typedef struct packed {
        logic [A_W-1:0]   a;
        logic [COL_W-1:0] d;
    } wr_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] c;
    } px_t;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     start;
    logic [NUM_P*COORD_W-1:0] p_x, p_y;
    logic [NUM_P-1:0]         p_valid;
    logic [NUM_P*COL_W-1:0]   p_col;
    logic [A_W-1:0]           mem_addr;
    logic [COL_W-1:0]         mem_wdata;
    logic                     mem_we;
    logic [COL_W-1:0]         mem_rdata;
    logic [X_W-1:0]           oX;
    logic [Y_W-1:0]           oY;
    logic [COL_W-1:0]         oColour;
    logic                     plot_enable, busy, done;

    logic [COL_W-1:0] ram [CELLS]       = '{default: '0};
    logic [COL_W-1:0] model_mem [CELLS] = '{default: '0};
    int  mprev_x [NUM_P];
    int  mprev_y [NUM_P];
    bit  mprev_v [NUM_P];
    wr_t wr_q[$];
    px_t pix_q[$];
    wr_t mon_w;
    px_t mon_p;
    int  checks = 0;
    int  errors = 0;

    board_render_fsm #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .TILE(TILE), .NUM_P(NUM_P), .COORD_W(COORD_W),
        .COL_W(COL_W), .X_W(X_W), .Y_W(Y_W), .A_W(A_W), .BG_COL(BG_COL), .HIT_COL(HIT_COL)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .p_x(p_x), .p_y(p_y), .p_valid(p_valid), .p_col(p_col),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .oX(oX), .oY(oY), .oColour(oColour),
        .plot_enable(plot_enable), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Board RAM with one cycle of read latency.
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // NOTE: outputs are sampled on the falling edge, well away from the active edge.
    always @(negedge clock) begin
        if (mem_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL mem_write: unexpected write addr=%0d data=%b", mem_addr, mem_wdata);
            end else begin
                mon_w = wr_q.pop_front();
                if (mem_addr !== mon_w.a || mem_wdata !== mon_w.d) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0d data=%b expected addr=%0d data=%b",
                             mem_addr, mem_wdata, mon_w.a, mon_w.d);
                end
            end
        end
        if (plot_enable) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: unexpected pixel x=%0d y=%0d c=%b", oX, oY, oColour);
            end else begin
                mon_p = pix_q.pop_front();
                if (oX !== mon_p.x || oY !== mon_p.y || oColour !== mon_p.c) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b",
                             oX, oY, oColour, mon_p.x, mon_p.y, mon_p.c);
                end
            end
        end
    end

    task automatic set_players(input int x0, input int y0, input logic [COL_W-1:0] c0, input bit v0,
                               input int x1, input int y1, input logic [COL_W-1:0] c1, input bit v1);
        p_x     = {COORD_W'(x1), COORD_W'(x0)};
        p_y     = {COORD_W'(y1), COORD_W'(y0)};
        p_col   = {c1, c0};
        p_valid = {v1, v0};
    endtask

    // Model of one pass: erase old cells, write new ones, then the full row-major scan.
    task automatic build_expect();
        int x, y, xj, yj;
        bit hit;
        wr_t w;
        px_t p;
        for (int i = 0; i < NUM_P; i++) begin
            if (mprev_v[i] && mprev_x[i] < GRID_W && mprev_y[i] < GRID_H) begin
                w.a = A_W'(mprev_y[i] * GRID_W + mprev_x[i]);
                w.d = BG_COL;
                wr_q.push_back(w);
                model_mem[mprev_y[i] * GRID_W + mprev_x[i]] = BG_COL;
            end
        end
        for (int i = 0; i < NUM_P; i++) begin
            x = int'(p_x[i*COORD_W +: COORD_W]);
            y = int'(p_y[i*COORD_W +: COORD_W]);
            if (p_valid[i] && x < GRID_W && y < GRID_H) begin
                hit = 0;
                for (int j = 0; j < NUM_P; j++) begin
                    xj = int'(p_x[j*COORD_W +: COORD_W]);
                    yj = int'(p_y[j*COORD_W +: COORD_W]);
                    if (j != i && p_valid[j] && xj == x && yj == y) hit = 1;
                end
                w.a = A_W'(y * GRID_W + x);
                w.d = hit ? HIT_COL : p_col[i*COL_W +: COL_W];
                wr_q.push_back(w);
                model_mem[y * GRID_W + x] = w.d;
            end
        end
        for (int i = 0; i < NUM_P; i++) begin
            mprev_x[i] = int'(p_x[i*COORD_W +: COORD_W]);
            mprev_y[i] = int'(p_y[i*COORD_W +: COORD_W]);
            mprev_v[i] = p_valid[i];
        end
        for (int cy = 0; cy < GRID_H; cy++)
            for (int cx = 0; cx < GRID_W; cx++)
                for (int py = 0; py < TILE; py++)
                    for (int px = 0; px < TILE; px++) begin
                        p.x = X_W'(cx * TILE + px);
                        p.y = Y_W'(cy * TILE + py);
                        p.c = model_mem[cy * GRID_W + cx];
                        pix_q.push_back(p);
                    end
    endtask

    task automatic run_pass(input string name, input bit hold);
        int lat;
        int idle_seen;
        build_expect();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        p_x     = (NUM_P*COORD_W)'($urandom);
        p_y     = (NUM_P*COORD_W)'($urandom);
        p_col   = (NUM_P*COL_W)'($urandom);
        p_valid = NUM_P'($urandom);
        lat = 0;
        idle_seen = 0;
        while (lat < LAT + 50) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            lat++;
            if (!busy) idle_seen++;
            if (done) break;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        end
        checks++;
        if (idle_seen != 0) begin
            errors++;
            $display("FAIL %s busy: low for %0d cycles expected 0", name, idle_seen);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy);
        end
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got busy=%b expected 0", name, busy);
        end
        checks++;
        if (wr_q.size() != 0 || pix_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftovers: got writes=%0d pixels=%0d expected 0 0", name, wr_q.size(), pix_q.size());
        end
    endtask

    task automatic check_cell(input string name, input int a, input logic [COL_W-1:0] exp);
        checks++;
        if (ram[a] !== exp) begin
            errors++;
            $display("FAIL %s cell %0d: got %b expected %b", name, a, ram[a], exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({busy, done, plot_enable, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL %s ctrl: got busy=%b done=%b plot=%b we=%b expected 0", name, busy, done, plot_enable, mem_we);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || oX !== '0 || oY !== '0 || oColour !== '0) begin
            errors++;
            $display("FAIL %s data: got addr=%0d wdata=%b x=%0d y=%0d c=%b expected all 0",
                     name, mem_addr, mem_wdata, oX, oY, oColour);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        set_players(0, 0, '0, 0, 0, 0, '0, 0);
        for (int i = 0; i < NUM_P; i++) mprev_v[i] = 0;
        #12;
        check_outputs_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        set_players(3, 5, 3'b100, 1, 10, 2, 3'b001, 1);
        run_pass("basic", 0);
        check_cell("basic", 83, 3'b100);
        check_cell("basic", 42, 3'b001);
    endtask

    task automatic test_move();
        set_players(4, 5, 3'b100, 1, 10, 2, 3'b001, 1);
        run_pass("move", 0);
        check_cell("move", 83, BG_COL);
        check_cell("move", 84, 3'b100);
        check_cell("move", 42, 3'b001);
    endtask

    task automatic test_collision();
        set_players(7, 7, 3'b100, 1, 7, 7, 3'b001, 1);
        run_pass("collision", 0);
        check_cell("collision", 119, HIT_COL);
    endtask

    task automatic test_hold_start();
        set_players(0, 15, 3'b101, 1, 15, 0, 3'b010, 1);
        run_pass("hold_start", 1);
        check_cell("hold_start", 119, BG_COL);
    endtask

    task automatic test_invalid();
        set_players(1, 2, 3'b111, 1, 16, 0, 3'b011, 1);
        run_pass("out_of_range", 0);
        check_cell("out_of_range", 0, BG_COL);
        set_players(1, 2, 3'b111, 1, 3, 3, 3'b010, 0);
        run_pass("slot_invalid", 0);
        check_cell("slot_invalid", 51, BG_COL);
    endtask

    task automatic test_reset_mid_pass();
        bit found;
        int bad;
        set_players(1, 1, 3'b011, 1, 2, 2, 3'b101, 1);
        build_expect();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clock);
            if (plot_enable && oX == X_W'(8 * TILE) && oY == Y_W'(2 * TILE)) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid reach_cell40: got found=0 expected 1");
        end
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid no_done: got %0d bad cycles expected 0", bad);
        end
        pix_q.delete();
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid writes: got %0d pending expected 0", wr_q.size());
        end
        for (int i = 0; i < NUM_P; i++) mprev_v[i] = 0;
        bad = 0;
        for (int a = 0; a < CELLS; a++) if (ram[a] !== model_mem[a]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid ram: got %0d differing cells expected 0", bad);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_after_reset();
        set_players(5, 5, 3'b010, 1, 6, 6, 3'b011, 1);
        run_pass("after_reset", 0);
        check_cell("after_reset", 17, 3'b011);
        check_cell("after_reset", 34, 3'b101);
        check_cell("after_reset", 85, 3'b010);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_move();
        test_collision();
        test_hold_start();
        test_invalid();
        test_reset_mid_pass();
        test_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
